ocupacion_parking: RTL
======================

Name: ocupacion_parking

Overview:
- Occupancy counter for the parking lot. Sits directly downstream of the per-gate car-passage detectors.
- Consumes one-cycle passage ticks from the entry gate and the exit gate. Maintains the number of parked cars in binary and in 3-digit BCD for the display stage.
- Flags full, empty, and sticky over/under-count errors.

Parameters:
CAPACITY, 120, max cars allowed; legal range 1..999
CNT_W, 10, width of binary count (must hold 999)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset (0 = reset asserted)
tick_in  in  1  one-cycle pulse: a car completed entry
tick_out  in  1  one-cycle pulse: a car completed exit
clear  in  1  synchronous clear of count and error flags
count  out  CNT_W  cars currently inside, binary
bcd2  out  4  hundreds digit of count
bcd1  out  4  tens digit of count
bcd0  out  4  units digit of count
full  out  1  count == CAPACITY
empty  out  1  count == 0
err_over  out  1  sticky: entry seen while full
err_under  out  1  sticky: exit seen while empty

Behaviour:
- Reset (reset=0, async) forces: count=0, bcd2/1/0=0, empty=1, full=0, err_over=0, err_under=0. Deassertion is synchronized by the normal clock edge. No tick is counted on the edge coinciding with deassertion if reset was still low.
- All outputs are registered. A tick sampled at edge N is reflected in count, bcd*, full and empty right after edge N (latency 1 clock).
- full and empty are always consistent with count and bcd* in the same cycle. They are derived from the next-state value, not delayed by an extra cycle.
- Ticks are level-sampled every cycle. A tick held high for k cycles counts k events. Edge detection is the upstream block's job.
- Per-edge decision, in priority order:
  1. clear=1: count=0, bcd=000, err_over=0, err_under=0; ticks in that cycle are ignored.
  2. tick_in=1 and tick_out=1: net zero, count unchanged. No error even when full or empty.
  3. tick_in only: if count<CAPACITY, increment; else hold and set err_over.
  4. tick_out only: if count>0, decrement; else hold and set err_under.
  5. no tick: hold.
- BCD is kept by a chained up/down BCD counter updated in lockstep with the binary count. There is no binary-to-BCD conversion.
  - Increment: digit 9 -> 0 with carry.
  - Decrement: digit 0 -> 9 with borrow.
  - Carry/borrow ripple combinationally within the cycle.
- BCD digits never hold values 10-15. count never exceeds CAPACITY and never underflows. No wrap-around is possible.
- Error flags stay set until clear or reset. They do not affect counting.
- Reset mid-operation drops everything to reset values immediately, regardless of clock.

Decomposition:
- Shared parking package holds:
  - CAP_MAX = 999
  - BCD digit width = 4
  - BCD_MAX_DIGIT = 9
  - tick encoding constants for {tick_in,tick_out}: NONE=2'b00, IN=2'b10, OUT=2'b01, BOTH=2'b11
- One sub-module: bcd_updown_digit.
  - Ports: clk, reset, en, up, clear, digit[3:0], carry_out, borrow_out.
  - Instantiated 3 times, chained.
  - The top gates en/up so a blocked increment/decrement never reaches the digits.

Test Plan:
- Reset: hold reset=0 for 3 clocks with tick_in=1 -> count=0, bcd=000, empty=1, full=0, errs=0. Release; first tick_in pulse -> count=1, empty=0 one clock later.
- BCD carry/borrow: 10 tick_in pulses from 0 -> count=10, bcd=0,1,0. Then 1 tick_out -> count=9, bcd=0,0,9. Then from 99 one tick_in -> bcd=1,0,0.
- Full (CAPACITY=5): 5 tick_in -> count=5, full=1. Sixth tick_in -> count stays 5, err_over=1. Then tick_out -> count=4, full=0, err_over still 1.
- Empty: from 0, tick_out -> count=0, err_under=1. Then tick_in and tick_out same cycle at count=0 -> count=0, no further change. Same at count=CAPACITY -> count unchanged, err_over unchanged.
- Clear priority: count=7 with both errs set; clear=1 with tick_in=1 same cycle -> count=0, bcd=000, err_over=0, err_under=0, empty=1.
- Async reset mid-run: count=42; drive reset=0 between clock edges -> all outputs go to reset values before the next edge. Stable after release with no spurious count.

Source files
------------

// File: rtl/ocupacion_parking_pkg.sv
// Shared constants for the parking occupancy counter: BCD digit limits,
// the largest supported capacity and the encoding of the two gate ticks.
package ocupacion_parking_pkg;

  localparam int CAP_MAX = 999;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX_DIGIT = 4'd9;

  // Encoding of {tick_in, tick_out} as seen on a single clock edge.
  typedef enum logic [1:0] {
    TICK_NONE = 2'b00,
    TICK_OUT  = 2'b01,
    TICK_IN   = 2'b10,
    TICK_BOTH = 2'b11
  } tick_e;

endpackage

// File: rtl/ocupacion_parking_if.sv
// Bundle of gate ticks, clear and occupancy outputs between the gate
// detectors / display stage (master) and the occupancy counter (slave).
interface ocupacion_parking_if #(
  parameter int CNT_W = 10
) ();
  import ocupacion_parking_pkg::*;

  logic             tick_in;
  logic             tick_out;
  logic             clear;
  logic [CNT_W-1:0] count;
  logic [BCD_W-1:0] bcd2;
  logic [BCD_W-1:0] bcd1;
  logic [BCD_W-1:0] bcd0;
  logic             full;
  logic             empty;
  logic             err_over;
  logic             err_under;

  modport master (
    output tick_in, tick_out, clear,
    input  count, bcd2, bcd1, bcd0, full, empty, err_over, err_under
  );

  modport slave (
    input  tick_in, tick_out, clear,
    output count, bcd2, bcd1, bcd0, full, empty, err_over, err_under
  );

endinterface

// File: rtl/ocupacion_parking_bcd_updown_digit.sv
// One decade of a chained up/down BCD counter. carry_out/borrow_out are
// combinational so a whole ripple across several digits settles in one cycle.
module bcd_updown_digit
  import ocupacion_parking_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out,
  output logic             borrow_out
);

  assign carry_out  = en & up & (digit == BCD_MAX_DIGIT);
  assign borrow_out = en & ~up & (digit == '0);

  // Digit register: wraps 9->0 going up and 0->9 going down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (en) begin
      if (up) begin
        digit <= (digit == BCD_MAX_DIGIT) ? '0 : digit + 4'd1;
      end else begin
        digit <= (digit == '0) ? BCD_MAX_DIGIT : digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/ocupacion_parking.sv
// Parking occupancy counter: counts entry/exit ticks in binary and in
// three BCD digits, flags full/empty and keeps sticky over/under errors.
module ocupacion_parking
  import ocupacion_parking_pkg::*;
#(
  parameter int CAPACITY = 120,
  parameter int CNT_W    = 10
) (
  input logic                 clk,
  input logic                 reset,
  ocupacion_parking_if.slave  bus
);

  localparam logic [CNT_W-1:0] CAP_L = CNT_W'(CAPACITY);

  tick_e            tick;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic             full_q;
  logic             empty_q;
  logic             err_over_q;
  logic             err_under_q;
  logic             step_en;
  logic             step_up;
  logic             set_over;
  logic             set_under;
  logic             carry0, carry1, carry2;
  logic             borrow0, borrow1, borrow2;
  logic [BCD_W-1:0] digit0, digit1, digit2;
  logic             unused_top_ripple;

  assign tick = tick_e'({bus.tick_in, bus.tick_out});

  // Decide this edge's action; a blocked step never enables the BCD chain.
  always_comb begin
    step_en    = 1'b0;
    step_up    = 1'b0;
    set_over   = 1'b0;
    set_under  = 1'b0;
    count_next = count_q;
    if (bus.clear) begin
      count_next = '0;
    end else begin
      case (tick)
        TICK_IN: begin
          if (count_q < CAP_L) begin
            step_en    = 1'b1;
            step_up    = 1'b1;
            count_next = count_q + CNT_W'(1);
          end else begin
            set_over = 1'b1;
          end
        end
        TICK_OUT: begin
          if (count_q != '0) begin
            step_en    = 1'b1;
            count_next = count_q - CNT_W'(1);
          end else begin
            set_under = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Binary count, status flags derived from the next count, sticky errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      err_over_q  <= 1'b0;
      err_under_q <= 1'b0;
    end else begin
      count_q     <= count_next;
      full_q      <= (count_next == CAP_L);
      empty_q     <= (count_next == '0);
      err_over_q  <= bus.clear ? 1'b0 : (err_over_q | set_over);
      err_under_q <= bus.clear ? 1'b0 : (err_under_q | set_under);
    end
  end

  bcd_updown_digit u_digit0 (
    .clk(clk), .reset(reset), .en(step_en), .up(step_up), .clear(bus.clear),
    .digit(digit0), .carry_out(carry0), .borrow_out(borrow0)
  );

  bcd_updown_digit u_digit1 (
    .clk(clk), .reset(reset), .en(carry0 | borrow0), .up(step_up), .clear(bus.clear),
    .digit(digit1), .carry_out(carry1), .borrow_out(borrow1)
  );

  bcd_updown_digit u_digit2 (
    .clk(clk), .reset(reset), .en(carry1 | borrow1), .up(step_up), .clear(bus.clear),
    .digit(digit2), .carry_out(carry2), .borrow_out(borrow2)
  );

  // The count is capped at 999, so the top digit can never ripple further.
  assign unused_top_ripple = carry2 | borrow2;

  assign bus.count     = count_q;
  assign bus.bcd0      = digit0;
  assign bus.bcd1      = digit1;
  assign bus.bcd2      = digit2;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.err_over  = err_over_q;
  assign bus.err_under = err_under_q;

endmodule
